// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single shared RAM port.
// Each grant lasts one complete RAM transaction. Every grant is preceded by
// one ARB cycle, so the memory always sees an idle cycle between transactions.
// Ties are broken round-robin, or in favour of port 1 when FIXED_PRIO = 1.

package ram_pkg;
   typedef enum logic [1:0] {
      RAM_IDLE   = 2'd0,
      RAM_BUSY   = 2'd1,
      RAM_ACCESS = 2'd2,
      RAM_DONE   = 2'd3
   } ram_state_t;
endpackage

module ram_arbiter
   import ram_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        nrst,
   // requester port 0
   input  logic        rq0_ren,
   input  logic [3:0]  rq0_wen,
   input  logic [31:0] rq0_addr,
   input  logic [31:0] rq0_store,
   output logic [31:0] rq0_load,
   output ram_state_t  rq0_state,
   // requester port 1
   input  logic        rq1_ren,
   input  logic [3:0]  rq1_wen,
   input  logic [31:0] rq1_addr,
   input  logic [31:0] rq1_store,
   output logic [31:0] rq1_load,
   output ram_state_t  rq1_state,
   // shared RAM port
   output logic        mem_ren,
   output logic [3:0]  mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_store,
   input  logic [31:0] mem_load,
   input  ram_state_t  mem_state,
   // current owner, one-hot
   output logic [1:0]  grant
);

   localparam logic [1:0] ST_ARB  = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   logic [1:0] state, state_nxt;
   logic       last_grant, last_grant_nxt;   // index of the port granted most recently
   logic       req0, req1;

   assign req0 = rq0_ren | (|rq0_wen);
   assign req1 = rq1_ren | (|rq1_wen);

   // Read data goes to both ports; it is meaningful only to the port seeing RAM_DONE.
   assign rq0_load = mem_load;
   assign rq1_load = mem_load;

   // State and arbitration history registers, synchronous active-low reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, whatever the statement order.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state      <= ST_ARB;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Next-state logic: pick an owner in ARB; release on DONE or when the owner withdraws.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case statement leaves a value held, which would infer a latch.
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         ST_ARB: begin
            if (req0 && req1) begin
               if (FIXED_PRIO || !last_grant) begin
                  state_nxt      = ST_OWN1;
                  last_grant_nxt = 1'b1;
               end else begin
                  state_nxt      = ST_OWN0;
                  last_grant_nxt = 1'b0;
               end
            end else if (req0) begin
               state_nxt      = ST_OWN0;
               last_grant_nxt = 1'b0;
            end else if (req1) begin
               state_nxt      = ST_OWN1;
               last_grant_nxt = 1'b1;
            end
         end
         ST_OWN0: if (mem_state == RAM_DONE || !req0) state_nxt = ST_ARB;
         ST_OWN1: if (mem_state == RAM_DONE || !req1) state_nxt = ST_ARB;
         default: state_nxt = ST_ARB;
      endcase
   end

   // Output steering: the owner drives the RAM and sees its status; the other port sees BUSY or IDLE.
   always_comb begin
      mem_ren   = 1'b0;
      mem_wen   = 4'b0000;
      mem_addr  = 32'h0;
      mem_store = 32'h0;
      grant     = 2'b00;
      rq0_state = req0 ? RAM_BUSY : RAM_IDLE;
      rq1_state = req1 ? RAM_BUSY : RAM_IDLE;
      case (state)
         ST_OWN0: begin
            mem_ren   = rq0_ren;
            mem_wen   = rq0_wen;
            mem_addr  = rq0_addr;
            mem_store = rq0_store;
            grant     = 2'b01;
            rq0_state = mem_state;
         end
         ST_OWN1: begin
            mem_ren   = rq1_ren;
            mem_wen   = rq1_wen;
            mem_addr  = rq1_addr;
            mem_store = rq1_store;
            grant     = 2'b10;
            rq1_state = mem_state;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter. Two instances share the stimulus:
// index 0 uses round-robin ties and index 1 uses fixed priority.
// Each instance drives its own small RAM model. That model answers
// RAM_DONE mem_lat cycles after the first cycle of a transaction.

module tb_ram_arbiter;
   import ram_pkg::*;

   logic        clk;
   logic        nrst;
   logic [1:0]  ren0, ren1;            // bit d drives instance d
   logic [3:0]  wen0, wen1;
   logic [31:0] addr0, addr1, store0, store1;
   logic [31:0] mload;

   logic [31:0] load0 [2];
   logic [31:0] load1 [2];
   ram_state_t  st0 [2];
   ram_state_t  st1 [2];
   logic        mren [2];
   logic [3:0]  mwen [2];
   logic [31:0] maddr [2];
   logic [31:0] mstore [2];
   ram_state_t  mstate [2];
   logic [1:0]  grant [2];
   logic [7:0]  mcnt [2];
   int          mem_lat;

   int total = 0;
   int bad   = 0;

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      ram_arbiter #(.FIXED_PRIO(g == 1)) u_dut (
         .clk      (clk),
         .nrst     (nrst),
         .rq0_ren  (ren0[g]),
         .rq0_wen  (wen0),
         .rq0_addr (addr0),
         .rq0_store(store0),
         .rq0_load (load0[g]),
         .rq0_state(st0[g]),
         .rq1_ren  (ren1[g]),
         .rq1_wen  (wen1),
         .rq1_addr (addr1),
         .rq1_store(store1),
         .rq1_load (load1[g]),
         .rq1_state(st1[g]),
         .mem_ren  (mren[g]),
         .mem_wen  (mwen[g]),
         .mem_addr (maddr[g]),
         .mem_store(mstore[g]),
         .mem_load (mload),
         .mem_state(mstate[g]),
         .grant    (grant[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: counts the active cycles of a transaction and returns to 0 whenever the port is idle.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!nrst || !(mren[d] || (|mwen[d]))) mcnt[d] <= 8'd0;
         else                                    mcnt[d] <= mcnt[d] + 8'd1;
      end
   end

   // RAM status: ACCESS while a transaction is active, DONE once mem_lat cycles have elapsed.
   always_comb begin
      for (int d = 0; d < 2; d++) begin
         mstate[d] = RAM_IDLE;
         if (mren[d] || (|mwen[d]))
            mstate[d] = (mcnt[d] == mem_lat[7:0]) ? RAM_DONE : RAM_ACCESS;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp_rr, exp_fp;
      int t, ph;
      nrst = 1'b0; ren0 = 2'b00; ren1 = 2'b00; wen0 = 4'h0; wen1 = 4'h0;
      addr0 = 32'h0; addr1 = 32'h0; store0 = 32'h0; store1 = 32'h0;
      mload = 32'hDEAD_BEEF; mem_lat = 2;

      // ---- reset state ----
      repeat (2) next_cycle();
      #1;
      chk("rst_grant",  32'(grant[0]), 32'h0);
      chk("rst_mren",   32'(mren[0]),  32'h0);
      chk("rst_maddr",  maddr[0],      32'h0);
      chk("rst_st0",    32'(st0[0]),   32'(RAM_IDLE));
      chk("rst_st1",    32'(st1[0]),   32'(RAM_IDLE));
      chk("load1_pass", load1[0],      32'hDEAD_BEEF);
      next_cycle();
      nrst = 1'b1;

      // ---- single read on port 0 ----
      next_cycle();
      ren0 = 2'b11; addr0 = 32'h0000_0010;
      #1;
      chk("rd_c0_st0",   32'(st0[0]),   32'(RAM_BUSY));
      chk("rd_c0_mren",  32'(mren[0]),  32'h0);
      next_cycle(); #1;
      chk("rd_c1_grant", 32'(grant[0]), 32'h1);
      chk("rd_c1_mren",  32'(mren[0]),  32'h1);
      chk("rd_c1_maddr", maddr[0],      32'h10);
      chk("rd_c1_st0",   32'(st0[0]),   32'(RAM_ACCESS));
      next_cycle(); #1;
      chk("rd_c2_st0",   32'(st0[0]),   32'(RAM_ACCESS));
      next_cycle(); #1;
      chk("rd_c3_st0",   32'(st0[0]),   32'(RAM_DONE));
      chk("rd_c3_load0", load0[0],      32'hDEAD_BEEF);
      ren0 = 2'b00;
      next_cycle(); #1;
      chk("rd_c4_grant", 32'(grant[0]), 32'h0);
      chk("rd_c4_mren",  32'(mren[0]),  32'h0);
      chk("rd_c4_st0",   32'(st0[0]),   32'(RAM_IDLE));

      // ---- fresh reset, then both ports request 3 transactions each ----
      next_cycle();
      nrst = 1'b0;
      next_cycle();
      nrst = 1'b1;
      for (int c = 0; c < 24; c++) begin
         next_cycle();
         if (c == 0) begin
            ren0 = 2'b11; ren1 = 2'b11; addr0 = 32'h100; addr1 = 32'h200;
         end
         if (c == 12) ren1[1] = 1'b0;   // fixed-priority port 1 has finished its three
         if (c == 20) ren0[0] = 1'b0;   // round-robin port 0 has finished its three
         #1;
         t  = c / 4;
         ph = c % 4;
         exp_rr = (ph == 0) ? 2'b00 : ((t % 2 == 0) ? 2'b01 : 2'b10);
         exp_fp = (ph == 0) ? 2'b00 : ((t < 3) ? 2'b10 : 2'b01);
         chk($sformatf("tie_rr_grant_c%0d", c), 32'(grant[0]), 32'(exp_rr));
         chk($sformatf("tie_fp_grant_c%0d", c), 32'(grant[1]), 32'(exp_fp));
         if (c < 12) chk($sformatf("tie_fp_st0_c%0d", c), 32'(st0[1]), 32'(RAM_BUSY));
      end
      next_cycle();
      ren0 = 2'b00; ren1 = 2'b00;
      #1;
      chk("tie_end_rr", 32'(grant[0]), 32'h0);
      chk("tie_end_fp", 32'(grant[1]), 32'h0);

      // ---- port 1 write waits while port 0 owns the RAM ----
      next_cycle();
      ren0 = 2'b11; addr0 = 32'h20;
      next_cycle();
      wen1 = 4'b1100; store1 = 32'h1234_5678; addr1 = 32'h40;
      #1;
      chk("wr_c1_grant", 32'(grant[0]), 32'h1);
      chk("wr_c1_mwen",  32'(mwen[0]),  32'h0);
      chk("wr_c1_st1",   32'(st1[0]),   32'(RAM_BUSY));
      next_cycle(); #1;
      chk("wr_c2_mwen",  32'(mwen[0]),  32'h0);
      next_cycle(); #1;
      chk("wr_c3_st0",   32'(st0[0]),   32'(RAM_DONE));
      chk("wr_c3_mwen",  32'(mwen[0]),  32'h0);
      ren0 = 2'b00;
      next_cycle(); #1;
      chk("wr_c4_grant", 32'(grant[0]), 32'h0);
      chk("wr_c4_mwen",  32'(mwen[0]),  32'h0);
      chk("wr_c4_st1",   32'(st1[0]),   32'(RAM_BUSY));
      next_cycle(); #1;
      chk("wr_c5_grant", 32'(grant[0]), 32'h2);
      chk("wr_c5_mwen",  32'(mwen[0]),  32'hC);
      chk("wr_c5_store", mstore[0],     32'h1234_5678);
      chk("wr_c5_addr",  maddr[0],      32'h40);
      next_cycle();
      next_cycle(); #1;
      chk("wr_c7_st1",   32'(st1[0]),   32'(RAM_DONE));
      wen1 = 4'h0;
      next_cycle(); #1;
      chk("wr_c8_mwen",  32'(mwen[0]),  32'h0);

      // ---- owner aborts before DONE ----
      mem_lat = 10;
      next_cycle();
      ren0 = 2'b11; addr0 = 32'h30;
      next_cycle(); #1;
      chk("ab_c1_grant", 32'(grant[0]), 32'h1);
      chk("ab_c1_st0",   32'(st0[0]),   32'(RAM_ACCESS));
      next_cycle();
      ren0 = 2'b00;
      #1;
      chk("ab_c2_mren",  32'(mren[0]),  32'h0);
      chk("ab_c2_nodone", 32'(st0[0] == RAM_DONE), 32'h0);
      next_cycle(); #1;
      chk("ab_c3_grant", 32'(grant[0]), 32'h0);
      chk("ab_c3_mren",  32'(mren[0]),  32'h0);
      chk("ab_c3_st0",   32'(st0[0]),   32'(RAM_IDLE));
      mem_lat = 2;

      // ---- reset pulse during OWN1, then a tie goes to port 0 ----
      next_cycle();
      ren1 = 2'b11; addr1 = 32'h80;
      next_cycle(); #1;
      chk("rs_c1_grant", 32'(grant[0]), 32'h2);
      next_cycle();
      nrst = 1'b0; ren0 = 2'b11;
      #1;
      chk("rs_c2_grant", 32'(grant[0]), 32'h2);
      next_cycle();
      nrst = 1'b1;
      #1;
      chk("rs_c3_grant", 32'(grant[0]), 32'h0);
      chk("rs_c3_mren",  32'(mren[0]),  32'h0);
      chk("rs_c3_maddr", maddr[0],      32'h0);
      chk("rs_c3_st1",   32'(st1[0]),   32'(RAM_BUSY));
      next_cycle(); #1;
      chk("rs_c4_grant", 32'(grant[0]), 32'h1);
      ren0 = 2'b00; ren1 = 2'b00;
      repeat (3) next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin on ties; 1 = port 1 always wins ties.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 nrst  in  1  reset, synchronous, active-low.
REQ-004 rq0_ren / rq1_ren  in  1  read request from port 0 / port 1.
REQ-005 rq0_wen / rq1_wen  in  4  byte write strobes from port 0 / port 1.
REQ-006 rq0_addr / rq1_addr  in  32  byte address from port 0 / port 1.
REQ-007 rq0_store / rq1_store  in  32  write data from port 0 / port 1.
REQ-008 rq0_load / rq1_load  out  32  read data to port 0 / port 1.
REQ-009 rq0_state / rq1_state  out  ram_state_t (2)  per-port status: RAM_IDLE, RAM_BUSY, RAM_ACCESS, RAM_DONE.
REQ-010 mem_ren  out  1;  mem_wen  out  4;  mem_addr  out  32;  mem_store  out  32: the single shared RAM port.
REQ-011 mem_load  in  32;  mem_state  in  ram_state_t: shared RAM response.
REQ-012 grant  out  2  one-hot current owner (bit0 = port 0, bit1 = port 1); 2'b00 when no owner.

Function
REQ-013 A port is "requesting" when its ren = 1 or its wen != 4'b0000.
REQ-014 FSM states: ARB, OWN0, OWN1.
REQ-015 ARB: mem_ren = 0, mem_wen = 0, mem_addr = 0, mem_store = 0.
REQ-016 ARB, only port n requesting: next state OWNn.
REQ-017 ARB, both requesting, FIXED_PRIO = 0: grant the port not granted last; last_grant resets to 1, so port 0 wins the first tie.
REQ-018 ARB, both requesting, FIXED_PRIO = 1: grant port 1.
REQ-019 ARB, no request: stay in ARB.
REQ-020 last_grant updates on every ARB->OWNn transition.
REQ-021 OWNn: mem_ren, mem_wen, mem_addr and mem_store equal port n inputs combinationally, every cycle.
REQ-022 OWNn: rqn_state = mem_state; the other port's state = RAM_BUSY if requesting, else RAM_IDLE.
REQ-023 ARB: each port's state = RAM_BUSY if requesting, else RAM_IDLE. A requester never sees RAM_DONE outside its own grant.
REQ-024 rq0_load and rq1_load equal mem_load at all times; the value is valid only when that port sees RAM_DONE.
REQ-025 OWNn with mem_state == RAM_DONE: next state ARB. The owner sees RAM_DONE for exactly that one cycle.
REQ-026 OWNn with port n no longer requesting (abort) and mem_state != RAM_DONE: next state ARB; the shared port is idle from the next cycle.
REQ-027 Latency: request held in ARB at edge k -> mem request visible in cycle k+1 -> owner sees DONE in the cycle mem_state = RAM_DONE.
REQ-028 Minimum cost: one ARB cycle between back-to-back grants, including repeat grants to the same port; the memory sees ren = 0 and wen = 0 for at least one cycle between transactions.
REQ-029 Requests are only evaluated in ARB; a request arriving during OWNn of the other port waits, and is not lost while held asserted.
REQ-030 grant = 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in ARB.

Reset
REQ-031 nrst = 0 at a clock edge forces: state ARB, last_grant = 1, grant = 0, all mem_* outputs 0, both rqn_state RAM_IDLE or RAM_BUSY per REQ-023.
REQ-032 Reset mid-transaction abandons the grant immediately; no RAM_DONE is issued to the former owner.

Verification
REQ-033 Single read: rq0_ren = 1, addr = 0x0000_0010; memory returns DONE 2 cycles after seeing ren with load = 0xDEAD_BEEF -> mem_addr = 0x10 from cycle 1; rq0_state = RAM_DONE, rq0_load = 0xDEAD_BEEF at cycle 3; then ARB.
REQ-034 Simultaneous requests, FIXED_PRIO = 0, both held for 3 transactions each -> grant order 01, 10, 01, 10, 01, 10; ARB cycle between each.
REQ-035 Same stimulus with FIXED_PRIO = 1 -> port 1 completes all 3 transactions before port 0 is granted; port 0 reads RAM_BUSY throughout.
REQ-036 Port 1 write, wen = 4'b1100, store = 0x1234_5678, while port 0 owns the port -> mem_wen stays 0000 until port 0's DONE plus one ARB cycle, then 1100 with store 0x1234_5678.
REQ-037 Owner drops ren before DONE -> ARB next cycle, mem_ren = 0, no RAM_DONE on that port.
REQ-038 nrst pulsed low during OWN1 -> next cycle grant = 00, mem_* = 0; with both requesting afterwards, port 0 is granted first.
